// File: rtl/mem_ctrl_if.sv
// Bus bundle between the multicycle control/datapath, mem_ctrl and the memory.
// The slave view is taken by mem_ctrl; the master view by whatever drives it.
interface mem_ctrl_if;
    // control / datapath side
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    // memory side
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        mack;
    logic [31:0] mrdata;

    modport slave (
        input  memread, memwrite, addr, wdata, mack, mrdata,
        output mreq, mwe, maddr, mwdata, rdata, stall, done, err
    );

    modport master (
        output memread, memwrite, addr, wdata, mack, mrdata,
        input  mreq, mwe, maddr, mwdata, rdata, stall, done, err
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory access controller for a multicycle CPU: IDLE -> BUSY -> DONE handshake.
// Optional busy timeout enabled by defining MEM_TIMEOUT_EN.
module mem_ctrl (
    input logic        clk,
    input logic        rst,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [31:0] TimeoutData = 32'hDEADBEEF;

    state_e      state_q;
    logic        mwe_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;
    logic [31:0] rdata_q;
    logic        req;

    assign req = bus.memread | bus.memwrite;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] cnt_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mwe_q    <= 1'b0;
            maddr_q  <= 32'd0;
            mwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        maddr_q  <= bus.addr;
                        mwdata_q <= bus.wdata;
                        mwe_q    <= bus.memwrite;
                        cnt_q    <= 4'd0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    // mack wins over a timeout landing in the same cycle
                    if (bus.mack) begin
                        if (!mwe_q) begin
                            rdata_q <= bus.mrdata;
                        end
                        state_q <= StDone;
                    end else if (cnt_q == 4'hF) begin
                        if (!mwe_q) begin
                            rdata_q <= TimeoutData;
                        end
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.err = err_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mwe_q    <= 1'b0;
            maddr_q  <= 32'd0;
            mwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        maddr_q  <= bus.addr;
                        mwdata_q <= bus.wdata;
                        mwe_q    <= bus.memwrite;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (bus.mack) begin
                        if (!mwe_q) begin
                            rdata_q <= bus.mrdata;
                        end
                        state_q <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.err = 1'b0;
`endif

    assign bus.mreq   = (state_q == StBusy);
    assign bus.done   = (state_q == StDone);
    assign bus.mwe    = mwe_q;
    assign bus.maddr  = maddr_q;
    assign bus.mwdata = mwdata_q;
    assign bus.rdata  = rdata_q;
    // Combinational so the control FSM holds in the very cycle it asks.
    assign bus.stall  = ((state_q == StIdle) && req) || (state_q == StBusy);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level model checked every cycle plus directed
// vectors with literal expectations. Build with MEM_TIMEOUT_EN to cover the timeout.
module tb_mem_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_en;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: an access is either waiting for its ack or just finished.
    bit          m_active;
    bit          m_fin;
    int          m_wait;
    bit          m_we;
    bit          m_err;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_fin    <= 1'b0;
            m_wait   <= 0;
            m_we     <= 1'b0;
            m_err    <= 1'b0;
            m_addr   <= 32'd0;
            m_wdata  <= 32'd0;
            m_rdata  <= 32'd0;
        end else if (m_fin) begin
            m_fin <= 1'b0;
        end else if (m_active) begin
            if (bus.mack) begin
                if (!m_we) m_rdata <= bus.mrdata;
                m_active <= 1'b0;
                m_fin    <= 1'b1;
            end else if (ToEn && (m_wait + 1 == 16)) begin
                if (!m_we) m_rdata <= 32'hDEADBEEF;
                m_err    <= 1'b1;
                m_active <= 1'b0;
                m_fin    <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (bus.memread || bus.memwrite) begin
            m_active <= 1'b1;
            m_wait   <= 0;
            m_we     <= bus.memwrite;
            m_addr   <= bus.addr;
            m_wdata  <= bus.wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mreq", {31'd0, bus.mreq}, {31'd0, m_active});
            if (m_active) chk("mwe", {31'd0, bus.mwe}, {31'd0, m_we});
            chk("maddr", bus.maddr, m_addr);
            chk("mwdata", bus.mwdata, m_wdata);
            chk("rdata", bus.rdata, m_rdata);
            chk("done", {31'd0, bus.done}, {31'd0, m_fin});
            chk("err", {31'd0, bus.err}, {31'd0, m_err});
            chk("stall", {31'd0, bus.stall},
                {31'd0, m_active || (!m_active && !m_fin && (bus.memread || bus.memwrite))});
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        bus.memread = 1'b0;
        bus.memwrite = 1'b0;
        bus.addr = 32'd0;
        bus.wdata = 32'd0;
        bus.mack = 1'b0;
        bus.mrdata = 32'd0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_maddr", bus.maddr, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        cyc();

        // Single-cycle read
        bus.memread = 1'b1; bus.addr = 32'h40;
        #1 chk("rd_c0_stall", {31'd0, bus.stall}, 32'd1);
        cyc();
        bus.memread = 1'b0; bus.mack = 1'b1; bus.mrdata = 32'h8C820004;
        #1 chk("rd_c1_mreq", {31'd0, bus.mreq}, 32'd1);
        chk("rd_c1_maddr", bus.maddr, 32'h40);
        cyc();
        bus.mack = 1'b0;
        #1 chk("rd_c2_done", {31'd0, bus.done}, 32'd1);
        chk("rd_c2_rdata", bus.rdata, 32'h8C820004);
        chk("rd_c2_mreq", {31'd0, bus.mreq}, 32'd0);
        cyc();

        // Write with three wait states
        bus.memwrite = 1'b1; bus.addr = 32'h54; bus.wdata = 32'h7;
        cyc();
        bus.memwrite = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            #1 chk("wr_mwe", {31'd0, bus.mwe}, 32'd1);
            chk("wr_maddr", bus.maddr, 32'h54);
            chk("wr_mwdata", bus.mwdata, 32'h7);
            cyc();
        end
        bus.mack = 1'b1; bus.mrdata = 32'h13579BDF;
        cyc();
        bus.mack = 1'b0;
        #1 chk("wr_c5_done", {31'd0, bus.done}, 32'd1);
        chk("wr_c5_rdata", bus.rdata, 32'h8C820004);
        cyc();

        // Request held through DONE: one DONE cycle, then a fresh access
        bus.memread = 1'b1; bus.addr = 32'h80;
        cyc();
        bus.mack = 1'b1; bus.mrdata = 32'h12345678;
        cyc();
        bus.mack = 1'b0;
        #1 chk("b2b_done", {31'd0, bus.done}, 32'd1);
        chk("b2b_done_stall", {31'd0, bus.stall}, 32'd0);
        cyc();
        #1 chk("b2b_idle_mreq", {31'd0, bus.mreq}, 32'd0);
        chk("b2b_idle_stall", {31'd0, bus.stall}, 32'd1);
        cyc();
        bus.memread = 1'b0;
        #1 chk("b2b_busy2", {31'd0, bus.mreq}, 32'd1);
        bus.mack = 1'b1; bus.mrdata = 32'hCAFEF00D;
        cyc();
        bus.mack = 1'b0;
        cyc();

        // Read+write together: write wins, rdata untouched; stray acks ignored
        bus.memread = 1'b1; bus.memwrite = 1'b1; bus.addr = 32'h100; bus.wdata = 32'hA5;
        cyc();
        bus.memread = 1'b0; bus.memwrite = 1'b0;
        #1 chk("rw_mwe", {31'd0, bus.mwe}, 32'd1);
        chk("rw_mwdata", bus.mwdata, 32'hA5);
        bus.mack = 1'b1; bus.mrdata = 32'h11111111;
        cyc();
        bus.mrdata = 32'h99;
        #1 chk("rw_rdata", bus.rdata, 32'hCAFEF00D);
        cyc();
        bus.mrdata = 32'hFFFFFFFF;
        cyc();
        bus.mack = 1'b0;
        #1 chk("stray_mreq", {31'd0, bus.mreq}, 32'd0);
        chk("stray_rdata", bus.rdata, 32'hCAFEF00D);
        cyc();

        // Reset in the third BUSY cycle abandons the access
        bus.memread = 1'b1; bus.addr = 32'h200;
        cyc();
        bus.memread = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        #1 chk("rstb_mreq_before", {31'd0, bus.mreq}, 32'd1);
        cyc();
        rst = 1'b0; bus.mack = 1'b1; bus.mrdata = 32'h55;
        #1 chk("rstb_mreq", {31'd0, bus.mreq}, 32'd0);
        chk("rstb_rdata", bus.rdata, 32'd0);
        chk("rstb_maddr", bus.maddr, 32'd0);
        cyc();
        bus.mack = 1'b0;
        #1 chk("rstb_late_rdata", bus.rdata, 32'd0);
        chk("rstb_late_done", {31'd0, bus.done}, 32'd0);
        cyc();

        // mack on the 16th BUSY cycle completes normally
        bus.memread = 1'b1; bus.addr = 32'h2F0;
        cyc();
        bus.memread = 1'b0;
        repeat (15) cyc();
        bus.mack = 1'b1; bus.mrdata = 32'h0BADF00D;
        cyc();
        bus.mack = 1'b0;
        #1 chk("ack16_done", {31'd0, bus.done}, 32'd1);
        chk("ack16_rdata", bus.rdata, 32'h0BADF00D);
        chk("ack16_err", {31'd0, bus.err}, 32'd0);
        cyc();

        // No ack at all
        bus.memread = 1'b1; bus.addr = 32'h300;
        cyc();
        bus.memread = 1'b0;
        repeat (16) cyc();
`ifdef MEM_TIMEOUT_EN
        #1 chk("to_done", {31'd0, bus.done}, 32'd1);
        chk("to_rdata", bus.rdata, 32'hDEADBEEF);
        chk("to_err", {31'd0, bus.err}, 32'd1);
        repeat (13) cyc();
        #1 chk("to_err_held", {31'd0, bus.err}, 32'd1);
`else
        #1 chk("nto_stall", {31'd0, bus.stall}, 32'd1);
        chk("nto_done", {31'd0, bus.done}, 32'd0);
        chk("nto_err", {31'd0, bus.err}, 32'd0);
        repeat (13) cyc();
        #1 chk("nto_stall_late", {31'd0, bus.stall}, 32'd1);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1 chk("end_err", {31'd0, bus.err}, 32'd0);
        chk("end_stall", {31'd0, bus.stall}, 32'd0);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on the rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 memread  in  1  control FSM requests a read (fetch or load) this cycle.
REQ-004 memwrite  in  1  control FSM requests a store this cycle.
REQ-005 addr  in  32  byte address from the datapath (PC or ALUOut, already muxed by iord).
REQ-006 wdata  in  32  store data.
REQ-007 mreq  out  1  request to the memory, high for the whole access.
REQ-008 mwe  out  1  write enable to the memory, valid while mreq.
REQ-009 maddr  out  32  latched address to the memory.
REQ-010 mwdata  out  32  latched store data to the memory.
REQ-011 mack  in  1  one-cycle memory acknowledge; counts only while mreq=1.
REQ-012 mrdata  in  32  read data from the memory, valid in the mack cycle.
REQ-013 rdata  out  32  registered read data to the IR and MDR.
REQ-014 stall  out  1  high while the control FSM must hold its state.
REQ-015 done  out  1  one-cycle pulse when an access completes.
REQ-016 err  out  1  sticky timeout flag (see Configuration).

Function
REQ-017 The block SHALL implement three states: IDLE, BUSY and DONE, encoded in a 2-bit enumerated state register.
REQ-018 In IDLE, if memread|memwrite=1, the block SHALL latch addr into maddr and wdata into mwdata, set mwe=memwrite, and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-019 If memread and memwrite are both high, the write SHALL win (mwe=1), and rdata SHALL be left unchanged.
REQ-020 mreq SHALL equal (state==BUSY); maddr, mwdata and mwe SHALL be held constant throughout BUSY.
REQ-021 In BUSY with mack=1, the block SHALL capture mrdata into rdata (read only) and go to DONE; without mack it SHALL stay in BUSY.
REQ-022 In DONE, done SHALL be 1, the inputs memread/memwrite SHALL be ignored, and the next state SHALL be IDLE unconditionally.
REQ-023 stall SHALL be combinational: stall = (state==IDLE && (memread|memwrite)) || state==BUSY.
REQ-024 Latency: with a request at cycle 0 and mack at cycle k≥1, done SHALL pulse at cycle k+1, and stall SHALL be high for cycles 0..k.
REQ-025 A mack received in IDLE or DONE SHALL be ignored, with no state or data change.
REQ-026 Back-to-back accesses SHALL be separated by exactly one DONE cycle; a request held high in DONE SHALL NOT start a second access.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set state=IDLE, mwe=0, maddr=0, mwdata=0, rdata=0 and err=0; mreq, stall and done SHALL then read 0.
REQ-028 Reset during BUSY SHALL abandon the access, with mreq low from the following cycle; a pending mack SHALL be discarded.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN: when defined, a 4-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without mack. If 16 BUSY cycles pass without mack, the block SHALL go to DONE, load rdata=32'hDEADBEEF (read only) and set err=1 until reset. A mack on the 16th cycle SHALL take priority over the timeout.
REQ-030 When MEM_TIMEOUT_EN is not defined, there SHALL be no counter, BUSY SHALL wait indefinitely, and err SHALL be tied to 0.

Verification
REQ-031 Read: memread=1 and addr=0x40 at cycle 0, then mack=1 with mrdata=0x8C820004 at cycle 1 -> mreq high in cycle 1 only, stall high in cycles 0-1, done and rdata=0x8C820004 in cycle 2.
REQ-032 Write with wait states: memwrite=1, addr=0x54, wdata=0x7 at cycle 0, mack at cycle 4 -> mwe=1, maddr=0x54 and mwdata=7 held in cycles 1-4, done in cycle 5, rdata unchanged.
REQ-033 Read and write both asserted with wdata=0xA5 -> mwe=1 and mwdata=0xA5; a stray mack in IDLE -> no state change.
REQ-034 rst asserted at the third BUSY cycle -> cycle after: state IDLE, mreq=0, rdata=0; a mack arriving after reset has no effect.
REQ-035 With MEM_TIMEOUT_EN defined, read with no mack -> done 17 cycles after the request, rdata=0xDEADBEEF, err=1 held until rst. Without the macro, stall stays high indefinitely and err=0.
